// File: rtl/fifo_fwft_bram_dp.sv
// -----------------------------------------------------------------------------
// bram_dp
// Simple dual-port RAM: one write port and one synchronous read port.
// When the read is not enabled, the read register keeps its last value.
// The read register is cleared by rst so that the FIFO presents zero data
// after a reset.
//
// Ports:
//   clk    in   1     clock
//   rst    in   1     synchronous active-high clear of the read register
//   we     in   1     write enable
//   waddr  in   W_A   write address
//   wdata  in   W_D   write data
//   re     in   1     read enable (captures mem[raddr] on the edge)
//   raddr  in   W_A   read address
//   q      out  W_D   registered read data
// -----------------------------------------------------------------------------
module bram_dp #(
   parameter int W_A = 10,
   parameter int W_D = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           we,
   input  logic [W_A-1:0] waddr,
   input  logic [W_D-1:0] wdata,
   input  logic           re,
   input  logic [W_A-1:0] raddr,
   output logic [W_D-1:0] q
);

   logic [W_D-1:0] mem [0:(2**W_A)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (re) begin
         q <= mem[raddr];
      end
   end

endmodule

// File: rtl/fifo_fwft.sv
// -----------------------------------------------------------------------------
// fifo_fwft
// Synchronous single-clock FIFO using all 2**ADDR_LEN entries, with an
// optional first-word-fall-through read side, an occupancy count,
// almost-empty / almost-full thresholds and sticky overflow / underflow flags.
//
// Ports:
//   clk                 in   1             clock
//   reset_i             in   1             synchronous active-high reset
//   reader_q_o          out  DATA_WIDTH    read data
//   reader_deq_i        in   1             dequeue request
//   reader_empty_o      out  1             no word available to the reader
//   reader_alm_empty_o  out  1             count <= ALM_EMPTY_THRESH
//   reader_underflow_o  out  1             sticky: dequeue while empty
//   writer_d_i          in   DATA_WIDTH    write data
//   writer_enq_i        in   1             enqueue request
//   writer_full_o       out  1             count == DEPTH
//   writer_alm_full_o   out  1             DEPTH - count <= ALM_FULL_THRESH
//   writer_overflow_o   out  1             sticky: enqueue while full
//   count_o             out  ADDR_LEN+1    stored entries, 0..DEPTH
//   clear_err_i         in   1             clears both sticky flags
// -----------------------------------------------------------------------------
module fifo_fwft #(
   parameter int ADDR_LEN         = 10,
   parameter int DATA_WIDTH       = 32,
   parameter int FWFT             = 1,
   parameter int ALM_EMPTY_THRESH = 1,
   parameter int ALM_FULL_THRESH  = 2
) (
   input  logic                  clk,
   input  logic                  reset_i,
   output logic [DATA_WIDTH-1:0] reader_q_o,
   input  logic                  reader_deq_i,
   output logic                  reader_empty_o,
   output logic                  reader_alm_empty_o,
   output logic                  reader_underflow_o,
   input  logic [DATA_WIDTH-1:0] writer_d_i,
   input  logic                  writer_enq_i,
   output logic                  writer_full_o,
   output logic                  writer_alm_full_o,
   output logic                  writer_overflow_o,
   output logic [ADDR_LEN:0]     count_o,
   input  logic                  clear_err_i
);

   localparam int DEPTH = 2**ADDR_LEN;

   localparam logic [ADDR_LEN:0] DEPTH_C = (ADDR_LEN+1)'(DEPTH);
   localparam logic [ADDR_LEN:0] ONE_C   = (ADDR_LEN+1)'(1);
   localparam logic [ADDR_LEN:0] TWO_C   = (ADDR_LEN+1)'(2);

   function automatic logic alm_empty_f(input logic [ADDR_LEN:0] c);
      return int'(c) <= ALM_EMPTY_THRESH;
   endfunction

   function automatic logic alm_full_f(input logic [ADDR_LEN:0] c);
      return (DEPTH - int'(c)) <= ALM_FULL_THRESH;
   endfunction

   logic [ADDR_LEN:0]   head;
   logic [ADDR_LEN:0]   tail;
   logic [ADDR_LEN:0]   count;
   logic [ADDR_LEN:0]   head_inc;
   logic                head_vld_p1;
   logic                full;
   logic                empty;
   logic                enq_acc;
   logic                deq_acc;
   logic                rd_en;
   logic [ADDR_LEN-1:0] rd_addr;
   logic                overflow;
   logic                underflow;

   always_comb begin
      head_inc = head + ONE_C;
      full     = (tail - head) == DEPTH_C;
      // In FWFT mode a word only becomes visible once it has been loaded
      // into the RAM read register, which lags the count by one edge.
      empty    = (FWFT != 0) ? !head_vld_p1 : (count == '0);
      enq_acc  = writer_enq_i && !full;
      deq_acc  = reader_deq_i && !empty;

      if (FWFT != 0) begin
         // On a dequeue, prefetch the next entry so it appears without a
         // bubble; with fewer than two entries that entry does not exist yet
         // (or is being written on this very edge), so leave the register.
         // Otherwise refill the register whenever it is empty but data exists.
         if (deq_acc) begin
            rd_addr = head_inc[ADDR_LEN-1:0];
            rd_en   = count >= TWO_C;
         end else begin
            rd_addr = head[ADDR_LEN-1:0];
            rd_en   = !head_vld_p1 && (count != '0);
         end
      end else begin
         rd_addr = head[ADDR_LEN-1:0];
         rd_en   = deq_acc;
      end
   end

   // Stage p0 -> p1: storage and registered read data
   bram_dp #(
      .W_A (ADDR_LEN),
      .W_D (DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .rst   (reset_i),
      .we    (enq_acc && !reset_i),
      .waddr (tail[ADDR_LEN-1:0]),
      .wdata (writer_d_i),
      .re    (rd_en && !reset_i),
      .raddr (rd_addr),
      .q     (reader_q_o)
   );

   always_ff @(posedge clk) begin
      if (reset_i) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         head_vld_p1 <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         if (enq_acc) begin
            tail <= tail + ONE_C;
         end
         if (deq_acc) begin
            head <= head_inc;
         end

         unique case ({enq_acc, deq_acc})
            2'b10:   count <= count + ONE_C;
            2'b01:   count <= count - ONE_C;
            default: count <= count;
         endcase

         if (deq_acc) begin
            head_vld_p1 <= count >= TWO_C;
         end else if (!head_vld_p1 && (count != '0)) begin
            head_vld_p1 <= 1'b1;
         end

         // A set event in the same cycle takes priority over the clear.
         if (writer_enq_i && full) begin
            overflow <= 1'b1;
         end else if (clear_err_i) begin
            overflow <= 1'b0;
         end

         if (reader_deq_i && empty) begin
            underflow <= 1'b1;
         end else if (clear_err_i) begin
            underflow <= 1'b0;
         end
      end
   end

   assign reader_empty_o     = empty;
   assign reader_alm_empty_o = alm_empty_f(count);
   assign reader_underflow_o = underflow;
   assign writer_full_o      = full;
   assign writer_alm_full_o  = alm_full_f(count);
   assign writer_overflow_o  = overflow;
   assign count_o            = count;

endmodule
